// File: rtl/dla_kpe_mac_pipe_pkg.sv
// Shared precision enums and default parameter constants for the KPE MAC pipeline.
package PKG_dla_typedef;

   typedef enum logic {
      IFMAP_16 = 1'b0,
      IFMAP_8  = 1'b1
   } precision_ifmap_e;

   typedef enum logic {
      WEIGHT_16 = 1'b0,
      WEIGHT_8  = 1'b1
   } precision_weight_e;

   localparam int DLA_KPE_LANES      = 4;
   localparam int DLA_KPE_ACC_W      = 40;
   localparam int DLA_KPE_MUL_STAGES = 2;

endpackage

// File: rtl/dla_kpe_mac_pipe_lane.sv
// One MAC lane: pipelined signed multiply, full/split saturating accumulator,
// sticky saturation flags and the registered result.
module dla_kpe_mac_lane
   import PKG_dla_typedef::*;
#(
   parameter int ACC_W      = DLA_KPE_ACC_W,
   parameter int MUL_STAGES = DLA_KPE_MUL_STAGES
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mul_en,
   input  logic [15:0]      in_a,
   input  logic [15:0]      in_b,
   input  logic             wt8,
   input  logic             acc_en,
   input  logic             acc_first,
   input  logic             acc_split,
   input  logic             out_load,
   output logic [ACC_W-1:0] out_acc,
   output logic [1:0]       out_sat
);

   localparam int          H  = ACC_W / 2;
   localparam int          W2 = ACC_W + 2;
   localparam int unsigned NS = MUL_STAGES;

   logic signed [15:0] a_s, b_ext;
   logic signed [7:0]  a_hi, a_lo;
   logic signed [31:0] prod_f;
   logic signed [23:0] prod_h, prod_l;
   logic signed [31:0] pf_q [NS];
   logic signed [23:0] ph_q [NS];
   logic signed [23:0] pl_q [NS];

   logic [ACC_W-1:0] acc_q, acc_nx, res_f;
   logic [1:0]       sat_q, sat_nx;
   logic [W2-1:0]    sum_f, sum_h, sum_l;
   logic [H-1:0]     res_h, res_l;
   logic             ovf_f, ovf_h, ovf_l;

   always_comb begin
      a_s    = in_a;
      a_hi   = in_a[15:8];
      a_lo   = in_a[7:0];
      b_ext  = wt8 ? {{8{in_b[7]}}, in_b[7:0]} : in_b;
      prod_f = 32'(a_s) * 32'(b_ext);
      prod_h = 24'(a_hi) * 24'(b_ext);
      prod_l = 24'(a_lo) * 24'(b_ext);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < NS; i++) begin
            pf_q[i] <= '0;
            ph_q[i] <= '0;
            pl_q[i] <= '0;
         end
      end else if (mul_en) begin
         pf_q[0] <= prod_f;
         ph_q[0] <= prod_h;
         pl_q[0] <= prod_l;
         for (int unsigned i = 1; i < NS; i++) begin
            pf_q[i] <= pf_q[i-1];
            ph_q[i] <= ph_q[i-1];
            pl_q[i] <= pl_q[i-1];
         end
      end
   end

   // Sums are formed two bits wider than the accumulator; overflow shows as
   // disagreement among the bits above the active sign bit.
   always_comb begin
      sum_f = (acc_first ? '0 : {{2{acc_q[ACC_W-1]}}, acc_q})
            + {{(W2-32){pf_q[NS-1][31]}}, pf_q[NS-1]};
      sum_h = (acc_first ? '0 : {{(W2-H){acc_q[ACC_W-1]}}, acc_q[ACC_W-1:H]})
            + {{(W2-24){ph_q[NS-1][23]}}, ph_q[NS-1]};
      sum_l = (acc_first ? '0 : {{(W2-H){acc_q[H-1]}}, acc_q[H-1:0]})
            + {{(W2-24){pl_q[NS-1][23]}}, pl_q[NS-1]};

      ovf_f = !((sum_f[W2-1:ACC_W-1] == '0) || (sum_f[W2-1:ACC_W-1] == '1));
      ovf_h = !((sum_h[W2-1:H-1] == '0) || (sum_h[W2-1:H-1] == '1));
      ovf_l = !((sum_l[W2-1:H-1] == '0) || (sum_l[W2-1:H-1] == '1));

      res_f = ovf_f ? {sum_f[W2-1], {(ACC_W-1){!sum_f[W2-1]}}} : sum_f[ACC_W-1:0];
      res_h = ovf_h ? {sum_h[W2-1], {(H-1){!sum_h[W2-1]}}} : sum_h[H-1:0];
      res_l = ovf_l ? {sum_l[W2-1], {(H-1){!sum_l[W2-1]}}} : sum_l[H-1:0];

      acc_nx = acc_split ? {res_h, res_l} : res_f;
      sat_nx = acc_split ? {ovf_h, ovf_l} : {2{ovf_f}};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc_q   <= '0;
         sat_q   <= '0;
         out_acc <= '0;
         out_sat <= '0;
      end else begin
         if (acc_en) begin
            acc_q <= acc_nx;
            sat_q <= acc_first ? sat_nx : (sat_q | sat_nx);
         end
         if (out_load) begin
            out_acc <= acc_q;
            out_sat <= sat_q;
         end
      end
   end

endmodule

// File: rtl/dla_kpe_mac_pipe.sv
// KPE multiply-accumulate pipeline: shared valid/first/last/stall control
// driving LANES independent MAC lanes.
module dla_kpe_mac_pipe
   import PKG_dla_typedef::*;
#(
   parameter int LANES      = DLA_KPE_LANES,
   parameter int ACC_W      = DLA_KPE_ACC_W,
   parameter int MUL_STAGES = DLA_KPE_MUL_STAGES
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic                   in_first,
   input  logic                   in_last,
   input  logic [LANES*16-1:0]    in_a,
   input  logic [LANES*16-1:0]    in_b,
   input  precision_ifmap_e       stgr_precision_ifmap,
   input  precision_weight_e      stgr_precision_weight,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [LANES*ACC_W-1:0] out_acc,
   output logic [LANES*2-1:0]     out_sat
);

   localparam int unsigned NS = MUL_STAGES;

   logic              adv, accept;
   precision_ifmap_e  grp_if, beat_if;
   precision_weight_e grp_wt, beat_wt;
   logic [NS-1:0]     v_q, f_q, l_q, s_q;
   logic              av_q, al_q;

   // The whole pipeline advances only when the output register can move.
   always_comb begin
      adv      = !(out_valid && !out_ready);
      in_ready = adv;
      accept   = in_valid && adv;
      beat_if  = in_first ? stgr_precision_ifmap  : grp_if;
      beat_wt  = in_first ? stgr_precision_weight : grp_wt;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         grp_if <= IFMAP_16;
         grp_wt <= WEIGHT_16;
      end else if (accept && in_first) begin
         grp_if <= stgr_precision_ifmap;
         grp_wt <= stgr_precision_weight;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         v_q       <= '0;
         f_q       <= '0;
         l_q       <= '0;
         s_q       <= '0;
         av_q      <= 1'b0;
         al_q      <= 1'b0;
         out_valid <= 1'b0;
      end else if (adv) begin
         v_q[0] <= accept;
         f_q[0] <= in_first;
         l_q[0] <= in_last;
         s_q[0] <= (beat_if == IFMAP_8);
         for (int unsigned i = 1; i < NS; i++) begin
            v_q[i] <= v_q[i-1];
            f_q[i] <= f_q[i-1];
            l_q[i] <= l_q[i-1];
            s_q[i] <= s_q[i-1];
         end
         av_q      <= v_q[NS-1];
         al_q      <= l_q[NS-1];
         out_valid <= av_q && al_q;
      end
   end

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      dla_kpe_mac_lane #(
         .ACC_W      (ACC_W),
         .MUL_STAGES (MUL_STAGES)
      ) u_lane (
         .clk       (clk),
         .rst       (rst),
         .mul_en    (adv),
         .in_a      (in_a[g*16 +: 16]),
         .in_b      (in_b[g*16 +: 16]),
         .wt8       (beat_wt == WEIGHT_8),
         .acc_en    (adv && v_q[NS-1]),
         .acc_first (f_q[NS-1]),
         .acc_split (s_q[NS-1]),
         .out_load  (adv && av_q && al_q),
         .out_acc   (out_acc[g*ACC_W +: ACC_W]),
         .out_sat   (out_sat[g*2 +: 2])
      );
   end

endmodule

// File: tb/tb_dla_kpe_mac_pipe.sv
// Randomised scoreboard bench for dla_kpe_mac_pipe against an arithmetic reference model.
module tb_dla_kpe_mac_pipe;
   import PKG_dla_typedef::*;

   localparam int LANES      = 4;
   localparam int ACC_W      = 34;
   localparam int MUL_STAGES = 2;
   localparam int H          = ACC_W / 2;

   logic                   clk = 1'b0;
   logic                   rst;
   logic                   in_valid, in_ready, in_first, in_last;
   logic [LANES*16-1:0]    in_a, in_b;
   precision_ifmap_e       pif;
   precision_weight_e      pwt;
   logic                   out_valid, out_ready;
   logic [LANES*ACC_W-1:0] out_acc;
   logic [LANES*2-1:0]     out_sat;

   always #5 clk = ~clk;

   dla_kpe_mac_pipe #(
      .LANES      (LANES),
      .ACC_W      (ACC_W),
      .MUL_STAGES (MUL_STAGES)
   ) dut (
      .clk                   (clk),
      .rst                   (rst),
      .in_valid              (in_valid),
      .in_ready              (in_ready),
      .in_first              (in_first),
      .in_last               (in_last),
      .in_a                  (in_a),
      .in_b                  (in_b),
      .stgr_precision_ifmap  (pif),
      .stgr_precision_weight (pwt),
      .out_valid             (out_valid),
      .out_ready             (out_ready),
      .out_acc               (out_acc),
      .out_sat               (out_sat)
   );

   int n_vec = 0;
   int n_err = 0;
   int ready_mode = 0;

   task automatic check(string name, logic [255:0] act, logic [255:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [LANES*ACC_W-1:0] acc;
      logic [LANES*2-1:0]     sat;
   } exp_t;

   exp_t             exp_q[$];
   logic [ACC_W-1:0] m_acc [LANES];
   logic [1:0]       m_sat [LANES];
   logic             m_if8, m_wt8;

   function automatic longint sx(logic [63:0] v, int w);
      logic [63:0] t;
      t = v << (64 - w);
      return $signed(t) >>> (64 - w);
   endfunction

   function automatic longint clamp(longint x, int w, output logic s);
      longint hi, lo;
      hi = (longint'(1) << (w - 1)) - 1;
      lo = -hi - 1;
      s  = 1'b0;
      if (x > hi) begin s = 1'b1; return hi; end
      if (x < lo) begin s = 1'b1; return lo; end
      return x;
   endfunction

   task automatic model_reset();
      for (int l = 0; l < LANES; l++) begin
         m_acc[l] = '0;
         m_sat[l] = '0;
      end
      m_if8 = 1'b0;
      m_wt8 = 1'b0;
      exp_q.delete();
   endtask

   task automatic model_beat();
      logic        if8, wt8, s, sh, sl;
      logic [15:0] a, b;
      longint      bw, r, rh, rl, base;
      exp_t        e;
      if8 = in_first ? (pif == IFMAP_8)  : m_if8;
      wt8 = in_first ? (pwt == WEIGHT_8) : m_wt8;
      if (in_first) begin
         m_if8 = if8;
         m_wt8 = wt8;
      end
      for (int l = 0; l < LANES; l++) begin
         a  = in_a[l*16 +: 16];
         b  = in_b[l*16 +: 16];
         bw = wt8 ? sx(64'(b[7:0]), 8) : sx(64'(b), 16);
         if (!if8) begin
            base     = in_first ? 64'sd0 : sx(64'(m_acc[l]), ACC_W);
            r        = clamp(base + sx(64'(a), 16) * bw, ACC_W, s);
            m_acc[l] = r[ACC_W-1:0];
            m_sat[l] = in_first ? {s, s} : (m_sat[l] | {s, s});
         end else begin
            base     = in_first ? 64'sd0 : sx(64'(m_acc[l][ACC_W-1:H]), H);
            rh       = clamp(base + sx(64'(a[15:8]), 8) * bw, H, sh);
            base     = in_first ? 64'sd0 : sx(64'(m_acc[l][H-1:0]), H);
            rl       = clamp(base + sx(64'(a[7:0]), 8) * bw, H, sl);
            m_acc[l] = {rh[H-1:0], rl[H-1:0]};
            m_sat[l] = in_first ? {sh, sl} : (m_sat[l] | {sh, sl});
         end
      end
      if (in_last) begin
         for (int l = 0; l < LANES; l++) begin
            e.acc[l*ACC_W +: ACC_W] = m_acc[l];
            e.sat[l*2 +: 2]         = m_sat[l];
         end
         exp_q.push_back(e);
      end
   endtask

   // ---------------- monitor / scoreboard ----------------
   logic                   pv = 1'b0, pr = 1'b1;
   logic [LANES*ACC_W-1:0] pacc;
   logic [LANES*2-1:0]     psat;

   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         model_reset();
         pv = 1'b0;
      end else begin
         check("in_ready_rule", 256'(in_ready), 256'(!(out_valid && !out_ready)));
         if (pv && !pr) begin
            check("hold_valid", 256'(out_valid), 256'(1));
            check("hold_acc", 256'(out_acc), 256'(pacc));
            check("hold_sat", 256'(out_sat), 256'(psat));
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_result: got acc %0h, expected no result", out_acc);
            end else begin
               e = exp_q.pop_front();
               check("result_acc", 256'(out_acc), 256'(e.acc));
               check("result_sat", 256'(out_sat), 256'(e.sat));
            end
         end
         pv   = out_valid;
         pr   = out_ready;
         pacc = out_acc;
         psat = out_sat;
         if (in_valid && in_ready) model_beat();
      end
   end

   always @(posedge clk) begin
      #1;
      case (ready_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = ($urandom_range(0, 3) != 0);
         default: out_ready = 1'b0;
      endcase
   end

   // ---------------- stimulus ----------------
   function automatic logic [15:0] rnd16();
      case ($urandom_range(0, 5))
         0:       return 16'h8000;
         1:       return 16'h7FFF;
         2:       return 16'hFFFF;
         default: return 16'($urandom);
      endcase
   endfunction

   function automatic logic [LANES*16-1:0] rnd_vec();
      logic [LANES*16-1:0] v;
      for (int l = 0; l < LANES; l++) v[l*16 +: 16] = rnd16();
      return v;
   endfunction

   task automatic send(logic first, logic last, logic [LANES*16-1:0] a,
                       logic [LANES*16-1:0] b, precision_ifmap_e pi,
                       precision_weight_e pw);
      int t = 0;
      in_valid = 1'b1;
      in_first = first;
      in_last  = last;
      in_a     = a;
      in_b     = b;
      pif      = pi;
      pwt      = pw;
      @(negedge clk);
      while (!in_ready) begin
         t++;
         if (t > 200) begin
            n_vec++;
            n_err++;
            $display("FAIL send_timeout: in_ready stuck at 0, required 1");
            in_valid = 1'b0;
            return;
         end
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic idle(int n);
      in_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(string name);
      for (int t = 0; t < 100 && !out_valid; t++) @(negedge clk);
      check(name, 256'(out_valid), 256'(1));
   endtask

   initial begin
      logic [LANES*16-1:0] av, bv;
      int                  len;
      precision_ifmap_e    pi;
      precision_weight_e   pw;

      rst       = 1'b0;
      in_valid  = 1'b0;
      in_first  = 1'b0;
      in_last   = 1'b0;
      in_a      = '0;
      in_b      = '0;
      pif       = IFMAP_16;
      pwt       = WEIGHT_16;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", 256'(out_valid), 256'(0));
      check("rst_in_ready", 256'(in_ready), 256'(1));
      check("rst_out_acc", 256'(out_acc), 256'(0));
      check("rst_out_sat", 256'(out_sat), 256'(0));
      rst = 1'b1;
      idle(1);

      // two-beat group, lane0 3*-5 + 7*2 = -1, with exact latency
      av = rnd_vec(); bv = rnd_vec();
      av[15:0] = 16'd3; bv[15:0] = 16'hFFFB;
      send(1'b1, 1'b0, av, bv, IFMAP_16, WEIGHT_16);
      av = rnd_vec(); bv = rnd_vec();
      av[15:0] = 16'd7; bv[15:0] = 16'd2;
      send(1'b0, 1'b1, av, bv, IFMAP_16, WEIGHT_16);
      for (int k = 0; k <= MUL_STAGES + 1; k++) begin
         @(negedge clk);
         check("latency_valid", 256'(out_valid), 256'(k == MUL_STAGES + 1));
         if (k == MUL_STAGES + 1) begin
            check("lane0_sum", 256'(out_acc[ACC_W-1:0]), 256'({ACC_W{1'b1}}));
            check("lane0_sat", 256'(out_sat[1:0]), 256'(0));
         end
      end
      @(posedge clk);
      #1;

      // split halves, hi=+128, lo=-127
      av = rnd_vec(); bv = rnd_vec();
      av[15:0] = 16'h807F; bv[15:0] = 16'h00FF;
      send(1'b1, 1'b1, av, bv, IFMAP_8, WEIGHT_8);
      idle(5);

      // full-width saturation, then flags clear on next group's first beat
      for (int k = 0; k < 10; k++)
         send(k == 0, k == 9, {LANES{16'h8000}}, {LANES{16'h8000}}, IFMAP_16, WEIGHT_16);
      send(1'b1, 1'b1, rnd_vec(), rnd_vec(), IFMAP_16, WEIGHT_8);
      idle(6);

      // output stall while four groups stream
      fork
         begin
            for (int g = 0; g < 4; g++) begin
               pi = precision_ifmap_e'(1'($urandom_range(0, 1)));
               pw = precision_weight_e'(1'($urandom_range(0, 1)));
               send(1'b1, 1'b0, rnd_vec(), rnd_vec(), pi, pw);
               send(1'b0, 1'b1, rnd_vec(), rnd_vec(), pi, pw);
            end
         end
         begin
            wait_valid("stall_wait_valid");
            ready_mode = 2;
            repeat (6) @(posedge clk);
            ready_mode = 0;
         end
      join
      idle(10);

      // precision changed mid-group must be ignored
      send(1'b1, 1'b0, rnd_vec(), rnd_vec(), IFMAP_8, WEIGHT_8);
      send(1'b0, 1'b0, rnd_vec(), rnd_vec(), IFMAP_16, WEIGHT_16);
      send(1'b0, 1'b1, rnd_vec(), rnd_vec(), IFMAP_16, WEIGHT_8);
      send(1'b1, 1'b0, rnd_vec(), rnd_vec(), IFMAP_16, WEIGHT_16);
      send(1'b0, 1'b1, rnd_vec(), rnd_vec(), IFMAP_8, WEIGHT_8);
      idle(6);

      // reset mid-group with a result pending
      ready_mode = 2;
      idle(1);
      send(1'b1, 1'b1, rnd_vec(), rnd_vec(), IFMAP_16, WEIGHT_16);
      send(1'b1, 1'b0, rnd_vec(), rnd_vec(), IFMAP_8, WEIGHT_16);
      wait_valid("pending_valid");
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check("midrst_out_valid", 256'(out_valid), 256'(0));
      check("midrst_in_ready", 256'(in_ready), 256'(1));
      check("midrst_out_acc", 256'(out_acc), 256'(0));
      ready_mode = 0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      send(1'b0, 1'b1, rnd_vec(), rnd_vec(), IFMAP_8, WEIGHT_8);
      send(1'b1, 1'b1, rnd_vec(), rnd_vec(), IFMAP_16, WEIGHT_16);
      idle(6);

      // randomised groups with random backpressure and idle gaps
      ready_mode = 1;
      for (int g = 0; g < 150; g++) begin
         len = $urandom_range(1, 4);
         for (int k = 0; k < len; k++) begin
            pi = precision_ifmap_e'(1'($urandom_range(0, 1)));
            pw = precision_weight_e'(1'($urandom_range(0, 1)));
            send(k == 0, k == len - 1, rnd_vec(), rnd_vec(), pi, pw);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
         end
      end

      ready_mode = 0;
      for (int t = 0; t < 200 && (exp_q.size() != 0 || out_valid); t++) @(negedge clk);
      check("drain_pending", 256'(exp_q.size()), 256'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
